// File: rtl/frame_mac_pkg.sv
// rtl/frame_mac_pkg.sv - shared types and width helper for the frame MAC stage
package frame_mac_pkg;

    // Sequencer states: wait for a frame, snapshot it, accumulate, hand off.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MAC  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Accumulator width that holds DEPTH full-scale products without overflow.
    function automatic int acc_width(input int width, input int depth);
        return 2 * width + $clog2(depth);
    endfunction

endpackage

// File: rtl/frame_mac_coef_rf.sv
// rtl/frame_mac_coef_rf.sv - coefficient register file with full parallel read
module frame_mac_coef_rf #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [IDX_W-1:0]             idx,
    input  logic [WIDTH-1:0]             data,
    output logic [DEPTH-1:0][WIDTH-1:0]  coefs
);

    // Single-port write, cleared on reset; every entry is visible at once
    // so the sequencer can snapshot the whole set in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            coefs <= '0;
        end else if (we) begin
            coefs[idx] <= data;
        end
    end

endmodule

// File: rtl/frame_mac.sv
// rtl/frame_mac.sv - serial dot product over one buffered frame with result handshake
module frame_mac
    import frame_mac_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = acc_width(WIDTH, DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena_in,
    input  logic [DEPTH-1:0][WIDTH-1:0]  frame_in,
    output logic                         rdy_out,
    input  logic                         coef_we,
    input  logic [$clog2(DEPTH)-1:0]     coef_idx,
    input  logic [WIDTH-1:0]             coef_data,
    output logic [ACC_WIDTH-1:0]         result,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic                         overrun
);

    localparam int              IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    state_t                        state;
    logic [IDX_W-1:0]              cnt;
    logic [IDX_W-1:0]              idx;
    logic [DEPTH-1:0][WIDTH-1:0]   coefs;
    logic [DEPTH-1:0][WIDTH-1:0]   f_snap;
    logic [DEPTH-1:0][WIDTH-1:0]   c_snap;
    logic [ACC_WIDTH-1:0]          acc;
    logic [2*WIDTH-1:0]            f_ext;
    logic [2*WIDTH-1:0]            c_ext;
    logic [2*WIDTH-1:0]            prod;
    logic [ACC_WIDTH-1:0]          acc_next;
    logic                          cnt_last;
    logic                          completing;

    frame_mac_coef_rf #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_coef_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (coef_we),
        .idx   (coef_idx),
        .data  (coef_data),
        .coefs (coefs)
    );

    // The next strobe would complete a frame; only accept it when the
    // sequencer is free to take it, everything else may stream freely.
    assign cnt_last   = (cnt == LAST);
    assign rdy_out    = !(cnt_last && (state != IDLE));
    assign completing = ena_in && cnt_last && rdy_out;

    // One shared multiplier walks the snapshot one index per cycle.
    assign f_ext    = {{WIDTH{1'b0}}, f_snap[idx]};
    assign c_ext    = {{WIDTH{1'b0}}, c_snap[idx]};
    assign prod     = f_ext * c_ext;
    assign acc_next = acc + ACC_WIDTH'(prod);

    // Word counter mirrors the upstream buffer; it keeps counting even on a
    // dropped completing strobe so both sides stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (ena_in) begin
            cnt <= cnt + IDX_W'(1);
        end
    end

    // Sticky flag for a completing strobe that arrived while held off.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (ena_in && !rdy_out) begin
            overrun <= 1'b1;
        end
    end

    // Sequencer: snapshot, accumulate DEPTH products, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            f_snap    <= '0;
            c_snap    <= '0;
            result    <= '0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (completing) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    f_snap <= frame_in;
                    c_snap <= coefs;
                    acc    <= '0;
                    idx    <= '0;
                    state  <= MAC;
                end
                MAC: begin
                    if (idx == LAST) begin
                        result    <= acc_next;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        acc <= acc_next;
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_mac.sv
// tb/tb_frame_mac.sv - scoreboard bench for frame_mac with directed frames
module tb_frame_mac;

    typedef logic [7:0][7:0] frame_t;

    logic        clk;
    logic        rst;
    logic        ena_in;
    frame_t      frame_in;
    logic        rdy_out;
    logic        coef_we;
    logic [2:0]  coef_idx;
    logic [7:0]  coef_data;
    logic [18:0] result;
    logic        res_valid;
    logic        res_ready;
    logic        overrun;

    int pass_cnt  = 0;
    int total_cnt = 0;
    longint exp_q[$];

    frame_mac dut (
        .clk       (clk),
        .rst       (rst),
        .ena_in    (ena_in),
        .frame_in  (frame_in),
        .rdy_out   (rdy_out),
        .coef_we   (coef_we),
        .coef_idx  (coef_idx),
        .coef_data (coef_data),
        .result    (result),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every accepted result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_result: got %0d expected none", result);
            end else begin
                check("result", longint'(result), exp_q.pop_front());
            end
        end
    end

    function automatic frame_t ramp();
        frame_t f;
        for (int i = 0; i < 8; i++) f[i] = 8'(i + 1);
        return f;
    endfunction

    function automatic frame_t fill(input logic [7:0] v);
        frame_t f;
        for (int i = 0; i < 8; i++) f[i] = v;
        return f;
    endfunction

    task automatic set_coefs_all(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            coef_we = 1'b1; coef_idx = 3'(i); coef_data = v;
            @(posedge clk); #1;
        end
        coef_we = 1'b0;
    endtask

    task automatic send_words(input int n);
        for (int i = 0; i < n; i++) begin
            ena_in = 1'b1;
            @(posedge clk); #1;
            ena_in = 1'b0;
        end
    endtask

    task automatic send_last(input frame_t f);
        frame_in = f;
        ena_in = 1'b1;
        @(posedge clk); #1;
        ena_in = 1'b0;
    endtask

    task automatic send_frame(input frame_t f);
        send_words(7);
        send_last(f);
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!res_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_valid_seen"}, longint'(res_valid), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int     n;
        int     seen;
        frame_t f;

        rst = 1'b1; ena_in = 1'b0; frame_in = '0; coef_we = 1'b0;
        coef_idx = '0; coef_data = '0; res_ready = 1'b1;
        do_reset();

        // Reset state
        check("reset_res_valid", longint'(res_valid), 0);
        check("reset_rdy_out", longint'(rdy_out), 1);
        check("reset_overrun", longint'(overrun), 0);
        check("reset_result", longint'(result), 0);

        // Ramp frame, unit coefficients: latency and one-cycle valid pulse
        set_coefs_all(8'd1);
        exp_q.push_back(36);
        send_frame(ramp());
        wait_valid("ramp", n);
        check("ramp_latency", n, 9);
        @(posedge clk); #1;
        check("ramp_valid_pulse", longint'(res_valid), 0);

        // Full-scale words and coefficients
        set_coefs_all(8'd255);
        exp_q.push_back(520200);
        send_frame(fill(8'd255));
        wait_valid("fullscale", n);
        @(posedge clk); #1;

        // Back-pressure: result held while the next frame streams in
        res_ready = 1'b0;
        exp_q.push_back(9180);
        send_frame(ramp());
        wait_valid("bp_first", n);
        send_words(7);
        check("bp_rdy_low", longint'(rdy_out), 0);
        check("bp_valid_held", longint'(res_valid), 1);
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_rdy_high", longint'(rdy_out), 1);
        check("bp_valid_dropped", longint'(res_valid), 0);
        exp_q.push_back(4080);
        send_last(fill(8'd2));
        wait_valid("bp_second", n);
        @(posedge clk); #1;

        // Overrun: completing strobe while held off is dropped
        res_ready = 1'b0;
        exp_q.push_back(2040);
        send_frame(fill(8'd1));
        wait_valid("ovr_first", n);
        send_words(7);
        check("ovr_rdy_low", longint'(rdy_out), 0);
        send_last(fill(8'd3));
        check("ovr_flag_set", longint'(overrun), 1);
        res_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (res_valid) seen++;
        end
        check("ovr_no_extra_result", seen, 0);
        check("ovr_flag_sticky", longint'(overrun), 1);
        do_reset();
        check("ovr_flag_cleared", longint'(overrun), 0);

        // Reset in the 4th MAC cycle aborts the frame and clears coefficients
        set_coefs_all(8'd1);
        send_frame(ramp());
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_res_valid", longint'(res_valid), 0);
        check("abort_rdy_out", longint'(rdy_out), 1);
        exp_q.push_back(0);
        send_frame(ramp());
        wait_valid("abort_zero_coefs", n);
        @(posedge clk); #1;
        set_coefs_all(8'd1);
        exp_q.push_back(36);
        send_frame(ramp());
        wait_valid("abort_reload", n);
        @(posedge clk); #1;

        // Coefficient write during LOAD applies only to the following frame
        do_reset();
        coef_we = 1'b1; coef_idx = 3'd0; coef_data = 8'd2;
        @(posedge clk); #1;
        coef_we = 1'b0;
        f = fill(8'd7);
        f[0] = 8'd10;
        exp_q.push_back(20);
        send_words(7);
        send_last(f);
        coef_we = 1'b1; coef_idx = 3'd0; coef_data = 8'd5;
        @(posedge clk); #1;
        coef_we = 1'b0;
        wait_valid("load_write_old", n);
        @(posedge clk); #1;
        exp_q.push_back(50);
        send_frame(f);
        wait_valid("load_write_new", n);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
